// File: rtl/lb_arb2.sv
// Two-master round-robin arbiter onto the shared SUMP2 local bus.
// One transaction at a time: IDLE -> ISSUE -> (WAIT_RD) -> DONE -> IDLE.

// Per-master completion registers: done/err pulse and held read data.
module lb_arb2_mport (
   input  logic        clk_lb,
   input  logic        reset_n,
   input  logic        fin,
   input  logic        sel,
   input  logic        err_in,
   input  logic [31:0] rd_in,
   output logic        done,
   output logic        err,
   output logic [31:0] rd_d
);
   always_ff @(posedge clk_lb or negedge reset_n) begin
      if (!reset_n) begin
         done <= 1'b0;
         err  <= 1'b0;
         rd_d <= 32'h0;
      end else begin
         done <= fin & sel;
         err  <= fin & sel & err_in;
         // rd_d only moves when this master completes; otherwise it holds
         if (fin && sel) rd_d <= rd_in;
      end
   end
endmodule

module lb_arb2 #(
   parameter logic [7:0]  TIMEOUT  = 8'd255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk_lb,
   input  logic        reset_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wr_d,
   output logic        m0_done,
   output logic        m0_err,
   output logic [31:0] m0_rd_d,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wr_d,
   output logic        m1_done,
   output logic        m1_err,
   output logic [31:0] m1_rd_d,
   output logic        lb_wr,
   output logic        lb_rd,
   output logic [31:0] lb_addr,
   output logic [31:0] lb_wr_d,
   input  logic [31:0] lb_rd_d,
   input  logic        lb_rd_rdy,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [31:0]       addr_d, wdat_d;
   logic              wr_stb_d, rd_stb_d;
   logic              fin, fin_err;
   logic [31:0]       fin_dat;

   logic [1:0]        req, we_in;
   logic [1:0][31:0]  addr_in, wd_in;
   logic [1:0]        done_v, err_v;
   logic [1:0][31:0]  rd_v;

   assign req     = {m1_req, m0_req};
   assign we_in   = {m1_we, m0_we};
   assign addr_in = {m1_addr, m0_addr};
   assign wd_in   = {m1_wr_d, m0_wr_d};

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      addr_d   = lb_addr;
      wdat_d   = lb_wr_d;
      wr_stb_d = 1'b0;
      rd_stb_d = 1'b0;
      fin      = 1'b0;
      fin_err  = 1'b0;
      fin_dat  = 32'h0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               // on a tie, the master that did not win last time goes
               gnt_d    = (&req) ? ~last_q : req[1];
               last_d   = gnt_d;
               we_d     = we_in[gnt_d];
               addr_d   = addr_in[gnt_d];
               wdat_d   = wd_in[gnt_d];
               wr_stb_d = we_d;
               rd_stb_d = ~we_d;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               fin     = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d   = 8'd0;
               state_d = WAIT_RD;
            end
         end
         WAIT_RD: begin
            // compare the incremented count so done lands TIMEOUT+1 after lb_rd;
            // rdy is tested first so it wins a coincident timeout
            cnt_d = cnt_q + 8'd1;
            if (lb_rd_rdy) begin
               fin     = 1'b1;
               fin_dat = lb_rd_d;
               state_d = DONE;
            end else if (cnt_d == TIMEOUT) begin
               fin     = 1'b1;
               fin_err = 1'b1;
               fin_dat = ERR_DATA;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_lb or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         cnt_q   <= 8'd0;
         lb_addr <= 32'h0;
         lb_wr_d <= 32'h0;
         lb_wr   <= 1'b0;
         lb_rd   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         lb_addr <= addr_d;
         lb_wr_d <= wdat_d;
         lb_wr   <= wr_stb_d;
         lb_rd   <= rd_stb_d;
         busy    <= (state_d != IDLE);
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_mport
      lb_arb2_mport u_mport (
         .clk_lb  (clk_lb),
         .reset_n (reset_n),
         .fin     (fin),
         .sel     (gnt_q == 1'(i)),
         .err_in  (fin_err),
         .rd_in   (fin_dat),
         .done    (done_v[i]),
         .err     (err_v[i]),
         .rd_d    (rd_v[i])
      );
   end

   assign m0_done = done_v[0];
   assign m1_done = done_v[1];
   assign m0_err  = err_v[0];
   assign m1_err  = err_v[1];
   assign m0_rd_d = rd_v[0];
   assign m1_rd_d = rd_v[1];
endmodule

// File: tb/tb_lb_arb2.sv
// Bench for lb_arb2: vector table + scoreboard of expected completions,
// plus hand sequences for back-to-back arbitration, stray rdy and reset.
module tb_lb_arb2;
   logic        clk_lb = 1'b0;
   logic        reset_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wr_d, m1_addr, m1_wr_d;
   logic        m0_done, m0_err, m1_done, m1_err;
   logic [31:0] m0_rd_d, m1_rd_d;
   logic        lb_wr, lb_rd, busy;
   logic [31:0] lb_addr, lb_wr_d, lb_rd_d;
   logic        lb_rd_rdy;

   always #5 clk_lb = ~clk_lb;

   lb_arb2 dut (
      .clk_lb(clk_lb), .reset_n(reset_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wr_d(m0_wr_d),
      .m0_done(m0_done), .m0_err(m0_err), .m0_rd_d(m0_rd_d),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wr_d(m1_wr_d),
      .m1_done(m1_done), .m1_err(m1_err), .m1_rd_d(m1_rd_d),
      .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
      .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy), .busy(busy)
   );

   typedef struct {
      bit mst; bit we; logic [31:0] addr; logic [31:0] wd;
      int dly; bit iss; logic [31:0] bus_d;
      bit e_err; logic [31:0] e_rd; int e_lat;
   } vec_t;

   typedef struct {
      bit mst; bit we; logic [31:0] addr; logic [31:0] wd;
      bit err; logic [31:0] rd; int lat;
   } exp_t;

   exp_t        sb[$];
   int          pass = 0, tot = 0, cyc = 0, strobe_cyc = 0;
   logic [31:0] hold [2];

   // slave model: rdy pulse dly cycles after lb_rd (0 = never answer)
   int          cur_dly = 0, scnt = 0;
   bit          cur_iss = 0;
   logic [31:0] cur_bus = 32'h0;
   logic        slv_rdy = 1'b0, stray = 1'b0;
   assign lb_rd_rdy = slv_rdy | stray;
   assign lb_rd_d   = cur_bus;

   always @(posedge clk_lb) cyc <= cyc + 1;

   always @(negedge clk_lb) begin
      slv_rdy = 1'b0;
      if (lb_rd) begin
         scnt    = cur_dly;
         slv_rdy = cur_iss;
      end else if (scnt > 0) begin
         scnt    = scnt - 1;
         slv_rdy = (scnt == 0);
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tot++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // scoreboard monitor: strobes and done pulses against the queue head
   always @(negedge clk_lb) begin
      if (reset_n) begin
         if (lb_wr || lb_rd) begin
            if (sb.size() == 0) begin
               tot++;
               $display("FAIL strobe: got bus strobe expected none");
            end else begin
               chk("strobe_both", 32'(lb_wr & lb_rd), 32'h0);
               chk("strobe_kind", 32'(lb_wr), 32'(sb[0].we));
               chk("strobe_addr", lb_addr, sb[0].addr);
               if (sb[0].we) chk("strobe_wd", lb_wr_d, sb[0].wd);
            end
            strobe_cyc = cyc;
         end
         if (m0_done || m1_done) begin
            if (sb.size() == 0) begin
               tot++;
               $display("FAIL done: got done %b%b expected none", m1_done, m0_done);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("done_sel", {30'h0, m1_done, m0_done}, e.mst ? 32'h2 : 32'h1);
               chk("err", 32'(e.mst ? m1_err : m0_err), 32'(e.err));
               chk("rd_d", e.mst ? m1_rd_d : m0_rd_d, e.rd);
               chk("other_rd_hold", e.mst ? m0_rd_d : m1_rd_d, hold[~e.mst]);
               chk("latency", 32'(cyc - strobe_cyc), 32'(e.lat));
               hold[e.mst] = e.rd;
            end
         end
      end
   end

   task automatic drive(bit m, bit r, bit we, logic [31:0] a, logic [31:0] wd);
      if (!m) begin m0_req = r; m0_we = we; m0_addr = a; m0_wr_d = wd; end
      else    begin m1_req = r; m1_we = we; m1_addr = a; m1_wr_d = wd; end
   endtask

   task automatic push(bit m, bit we, logic [31:0] a, logic [31:0] wd,
                       bit err, logic [31:0] rd, int lat);
      exp_t e;
      e.mst = m; e.we = we; e.addr = a; e.wd = wd; e.err = err; e.rd = rd; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic wait_done(bit m);
      bit seen = 1'b0;
      for (int n = 0; n < 600 && !seen; n++) begin
         @(negedge clk_lb);
         seen = m ? m1_done : m0_done;
      end
      if (!seen) begin
         tot++;
         $display("FAIL wait_done: got no m%0d_done expected one within 600 cycles", m);
      end
   endtask

   task automatic run_vec(vec_t v);
      cur_dly = v.dly; cur_iss = v.iss; cur_bus = v.bus_d;
      push(v.mst, v.we, v.addr, v.wd, v.e_err, v.e_rd, v.e_lat);
      drive(v.mst, 1'b1, v.we, v.addr, v.wd);
      wait_done(v.mst);
      drive(v.mst, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_lb);
      chk("idle_busy", 32'(busy), 32'h0);
   endtask

   task automatic chk_zero(string nm);
      chk({nm, "_flags"}, {25'h0, m0_done, m1_done, m0_err, m1_err, lb_wr, lb_rd, busy}, 32'h0);
      chk({nm, "_lb_addr"}, lb_addr, 32'h0);
      chk({nm, "_lb_wr_d"}, lb_wr_d, 32'h0);
      chk({nm, "_m0_rd_d"}, m0_rd_d, 32'h0);
      chk({nm, "_m1_rd_d"}, m1_rd_d, 32'h0);
   endtask

   vec_t vt [8];

   initial begin
      hold[0] = 32'h0; hold[1] = 32'h0;
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      //          mst we  addr          wd            dly  iss bus_d         err e_rd          lat
      vt[0] = '{1'b0, 1'b1, 32'h0,      32'h1,        0,   1'b0, 32'h0,      1'b0, 32'h0,      1};
      vt[1] = '{1'b1, 1'b0, 32'h4,      32'h0,        3,   1'b0, 32'hA5A50003, 1'b0, 32'hA5A50003, 4};
      vt[2] = '{1'b0, 1'b0, 32'h8,      32'h0,        0,   1'b0, 32'h11111111, 1'b1, 32'hDEADBEEF, 256};
      vt[3] = '{1'b1, 1'b0, 32'hC,      32'h0,        255, 1'b0, 32'h12345678, 1'b0, 32'h12345678, 256};
      vt[4] = '{1'b0, 1'b0, 32'h10,     32'h0,        1,   1'b1, 32'hCAFE0001, 1'b0, 32'hCAFE0001, 2};
      vt[5] = '{1'b1, 1'b1, 32'h14,     32'h55,       0,   1'b0, 32'h0,      1'b0, 32'h0,      1};
      vt[6] = '{1'b1, 1'b0, 32'h18,     32'h0,        256, 1'b0, 32'h22222222, 1'b1, 32'hDEADBEEF, 256};
      vt[7] = '{1'b0, 1'b0, 32'h1C,     32'h0,        2,   1'b0, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 3};

      repeat (2) @(negedge clk_lb);
      chk_zero("reset");
      reset_n = 1'b1;
      @(negedge clk_lb);

      // both masters request writes continuously: m0 wins the first tie
      for (int i = 0; i < 4; i++)
         push(i[0], 1'b1, i[0] ? 32'h200 : 32'h100, i[0] ? 32'h22 : 32'h11, 1'b0, 32'h0, 1);
      drive(1'b0, 1'b1, 1'b1, 32'h100, 32'h11);
      drive(1'b1, 1'b1, 1'b1, 32'h200, 32'h22);
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk_lb);
         chk("rr_busy", 32'(busy), (j % 3 != 0) ? 32'h1 : 32'h0);
         if (j == 11) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         end
      end

      for (int i = 0; i < 8; i++) run_vec(vt[i]);

      // stray rdy while idle must not start or finish anything
      stray = 1'b1;
      @(negedge clk_lb);
      stray = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk_lb);
         chk("stray_busy", 32'(busy), 32'h0);
      end

      // reset in WAIT_RD abandons the read; held m1 request regranted after
      cur_dly = 0; cur_iss = 1'b0;
      push(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 0);
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      begin
         bit seen = 1'b0;
         for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk_lb);
            seen = lb_rd;
         end
         if (!seen) begin
            tot++;
            $display("FAIL rst_strobe: got no lb_rd expected one within 10 cycles");
         end
      end
      repeat (3) @(negedge clk_lb);
      reset_n = 1'b0;
      #1;
      chk_zero("midrst");
      sb.delete();
      hold[0] = 32'h0; hold[1] = 32'h0;
      @(negedge clk_lb);
      chk_zero("midrst_hold");
      cur_dly = 2; cur_bus = 32'h00000077;
      push(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h00000077, 3);
      reset_n = 1'b1;
      wait_done(1'b1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_lb);
      chk("end_busy", 32'(busy), 32'h0);
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", pass, tot);
      $finish;
   end
endmodule
